wb_arbiter: RTL and testbench

Register-file write-port arbiter for the RV32I core. It shares the single register-file write port between three execution sources: the U-type unit (LUI/AUIPC results), the I/R-type ALU, and the load unit. Arbitration is round-robin with a valid/ready handshake per requester. The winning result is registered onto the write port one cycle later.

---
 rtl/wb_arbiter.sv | 112 +++++++++++
 tb/tb_wb_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the
// U-type unit, the I/R ALU and the load unit; the winner is registered onto the port.
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iU_VALID,
    input  logic [ADDR_W-1:0] iU_RD,
    input  logic [DATA_W-1:0] iU_DATA,
    output logic              oU_READY,
    input  logic              iA_VALID,
    input  logic [ADDR_W-1:0] iA_RD,
    input  logic [DATA_W-1:0] iA_DATA,
    output logic              oA_READY,
    input  logic              iL_VALID,
    input  logic [ADDR_W-1:0] iL_RD,
    input  logic [DATA_W-1:0] iL_DATA,
    output logic              oL_READY,
    input  logic              iSTALL,
    output logic              oWE,
    output logic [ADDR_W-1:0] oWADDR,
    output logic [DATA_W-1:0] oWDATA,
    output logic [1:0]        oGNT,
    output logic              oBUSY
);

    logic [1:0]        r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic [1:0]        w_win;
    logic              w_any;
    logic              w_multi;
    logic              w_grant;
    logic [ADDR_W-1:0] w_rd;
    logic [DATA_W-1:0] w_data;

    assign w_any   = iU_VALID | iA_VALID | iL_VALID;
    assign w_multi = (iU_VALID & iA_VALID) | (iA_VALID & iL_VALID) | (iU_VALID & iL_VALID);
    assign w_grant = !iRST && !iSTALL && w_any;

    // Priority order starts after the last winner; an illegal pointer of 3 behaves as 2.
    always_comb begin
        w_win = 2'd0;
        case (r_last)
            2'd0: begin
                if (iA_VALID)      w_win = 2'd1;
                else if (iL_VALID) w_win = 2'd2;
                else               w_win = 2'd0;
            end
            2'd1: begin
                if (iL_VALID)      w_win = 2'd2;
                else if (iU_VALID) w_win = 2'd0;
                else               w_win = 2'd1;
            end
            default: begin
                if (iU_VALID)      w_win = 2'd0;
                else if (iA_VALID) w_win = 2'd1;
                else               w_win = 2'd2;
            end
        endcase
    end

    always_comb begin
        w_rd   = iU_RD;
        w_data = iU_DATA;
        case (w_win)
            2'd1: begin
                w_rd   = iA_RD;
                w_data = iA_DATA;
            end
            2'd2: begin
                w_rd   = iL_RD;
                w_data = iL_DATA;
            end
            default: begin
                w_rd   = iU_RD;
                w_data = iU_DATA;
            end
        endcase
    end

    assign oU_READY = w_grant && (w_win == 2'd0);
    assign oA_READY = w_grant && (w_win == 2'd1);
    assign oL_READY = w_grant && (w_win == 2'd2);
    assign oBUSY    = (w_any && !w_grant) || w_multi;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_last  <= 2'd2;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_last  <= w_win;
            r_we    <= (w_rd != '0);
            r_waddr <= w_rd;
            r_wdata <= w_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign oWE    = r_we;
    assign oWADDR = r_waddr;
    assign oWDATA = r_wdata;
    assign oGNT   = r_last;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single grants, round-robin rotation,
// x0 writes, stall, reset mid-stream and fairness after idle.
module tb_wb_arbiter;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iU_VALID, iA_VALID, iL_VALID;
    logic [4:0]  iU_RD, iA_RD, iL_RD;
    logic [31:0] iU_DATA, iA_DATA, iL_DATA;
    logic        oU_READY, oA_READY, oL_READY;
    logic        iSTALL;
    logic        oWE;
    logic [4:0]  oWADDR;
    logic [31:0] oWDATA;
    logic [1:0]  oGNT;
    logic        oBUSY;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [1:0]  exp_gnt [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [4:0]  exp_adr [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    logic [31:0] exp_dat [6] = '{32'hA, 32'hB, 32'hC, 32'hA, 32'hB, 32'hC};
    logic [2:0]  exp_rdy [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    always #5 iCLK = ~iCLK;

    wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iU_VALID(iU_VALID), .iU_RD(iU_RD), .iU_DATA(iU_DATA), .oU_READY(oU_READY),
        .iA_VALID(iA_VALID), .iA_RD(iA_RD), .iA_DATA(iA_DATA), .oA_READY(oA_READY),
        .iL_VALID(iL_VALID), .iL_RD(iL_RD), .iL_DATA(iL_DATA), .oL_READY(oL_READY),
        .iSTALL(iSTALL), .oWE(oWE), .oWADDR(oWADDR), .oWDATA(oWDATA),
        .oGNT(oGNT), .oBUSY(oBUSY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [31:0] rdy();
        return {29'd0, oL_READY, oA_READY, oU_READY};
    endfunction

    initial begin
        iRST = 1'b1; iSTALL = 1'b0;
        iU_VALID = 1'b0; iA_VALID = 1'b0; iL_VALID = 1'b0;
        iU_RD = '0; iA_RD = '0; iL_RD = '0;
        iU_DATA = '0; iA_DATA = '0; iL_DATA = '0;
        tick();
        tick();
        chk("rst_we", oWE, 0);
        chk("rst_waddr", oWADDR, 0);
        chk("rst_wdata", oWDATA, 0);
        chk("rst_gnt", oGNT, 2);
        iU_VALID = 1'b1;
        #1 chk("rst_ready", rdy(), 3'b000);
        tick();
        chk("rst_we_valid", oWE, 0);

        // single U request
        iRST = 1'b0; iU_RD = 5'd5; iU_DATA = 32'h1234_5000;
        #1 chk("u_ready", rdy(), 3'b001);
        chk("u_busy", oBUSY, 0);
        tick();
        chk("u_we", oWE, 1);
        chk("u_waddr", oWADDR, 5);
        chk("u_wdata", oWDATA, 32'h1234_5000);
        chk("u_gnt", oGNT, 0);
        iU_VALID = 1'b0;
        tick();
        chk("u_we_drop", oWE, 0);
        chk("u_waddr_hold", oWADDR, 5);

        // write to x0 from A
        iA_VALID = 1'b1; iA_RD = 5'd0; iA_DATA = 32'hFFFF_FFFF;
        #1 chk("x0_ready", rdy(), 3'b010);
        tick();
        chk("x0_we", oWE, 0);
        chk("x0_gnt", oGNT, 1);
        chk("x0_wdata", oWDATA, 32'hFFFF_FFFF);
        iA_VALID = 1'b0;

        // stall with L pending
        iSTALL = 1'b1; iL_VALID = 1'b1; iL_RD = 5'd7; iL_DATA = 32'h77;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ready", rdy(), 3'b000);
            chk("stall_busy", oBUSY, 1);
            tick();
            chk("stall_we", oWE, 0);
            chk("stall_gnt", oGNT, 1);
        end
        iSTALL = 1'b0;
        #1 chk("unstall_ready", rdy(), 3'b100);
        tick();
        iSTALL = 1'b1; iL_VALID = 1'b0;
        #1 chk("unstall_we", oWE, 1);
        chk("unstall_waddr", oWADDR, 7);
        chk("unstall_gnt", oGNT, 2);
        iSTALL = 1'b0;

        // all three valid: rotation U,A,L,U,A,L
        iU_VALID = 1'b1; iU_RD = 5'd1; iU_DATA = 32'hA;
        iA_VALID = 1'b1; iA_RD = 5'd2; iA_DATA = 32'hB;
        iL_VALID = 1'b1; iL_RD = 5'd3; iL_DATA = 32'hC;
        for (int i = 0; i < 6; i++) begin
            #1 chk("rr_ready", rdy(), {29'd0, exp_rdy[i]});
            chk("rr_busy", oBUSY, 1);
            tick();
            chk("rr_we", oWE, 1);
            chk("rr_waddr", oWADDR, {27'd0, exp_adr[i]});
            chk("rr_wdata", oWDATA, exp_dat[i]);
            chk("rr_gnt", oGNT, {30'd0, exp_gnt[i]});
        end

        // idle after L, then U and A together
        iU_VALID = 1'b0; iA_VALID = 1'b0; iL_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_we", oWE, 0);
            chk("idle_gnt", oGNT, 2);
        end
        iU_VALID = 1'b1; iU_RD = 5'd9;  iU_DATA = 32'h9;
        iA_VALID = 1'b1; iA_RD = 5'd10; iA_DATA = 32'h10;
        #1 chk("fair_ready_u", rdy(), 3'b001);
        chk("fair_busy", oBUSY, 1);
        tick();
        chk("fair_waddr_u", oWADDR, 9);
        chk("fair_gnt_u", oGNT, 0);
        iU_VALID = 1'b0;
        #1 chk("fair_ready_a", rdy(), 3'b010);
        chk("fair_busy_a", oBUSY, 0);
        tick();
        chk("fair_waddr_a", oWADDR, 10);
        chk("fair_gnt_a", oGNT, 1);
        iA_VALID = 1'b0;

        // bring pointer to U so that A would win next, then reset mid-stream
        iU_VALID = 1'b1; iU_RD = 5'd4; iU_DATA = 32'h4;
        tick();
        chk("pre_gnt", oGNT, 0);
        iU_RD = 5'd1; iU_DATA = 32'hA;
        iA_VALID = 1'b1; iL_VALID = 1'b1;
        iRST = 1'b1;
        #1 chk("midrst_ready", rdy(), 3'b000);
        tick();
        chk("midrst_we", oWE, 0);
        chk("midrst_gnt", oGNT, 2);
        chk("midrst_waddr", oWADDR, 0);
        iRST = 1'b0;
        #1 chk("postrst_ready", rdy(), 3'b001);
        tick();
        chk("postrst_we", oWE, 1);
        chk("postrst_waddr", oWADDR, 1);
        chk("postrst_gnt", oGNT, 0);
        iU_VALID = 1'b0; iA_VALID = 1'b0; iL_VALID = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
